mem_arb: RTL and testbench

- Arbiter and sequencer for the single-ported unified SISC memory.
- Shares the memory between the instruction-fetch path (if_*) and the load/store data path (dm_*).
- Issues one access at a time, waits a fixed memory latency, and returns read data with a one-cycle ready pulse.
- Data accesses have priority; a starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_arb_if.sv | 32 +++
 rtl/mem_arb.sv | 163 ++++++++++++++++
 tb/tb_mem_arb.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Requester and memory-side signal bundle for the unified SISC memory arbiter.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface mem_arb_if #(
   parameter int AW = 16,
   parameter int DW = 32
) ();
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_rdy;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_rdy;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdy, if_rdata, dm_rdy, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdy, if_rdata, dm_rdy, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb.sv
// Fetch/data arbiter and access sequencer for the single-ported SISC memory.
// One access at a time: IDLE -> ISSUE -> WAIT -> RESP, data priority with a fetch starvation guard.
module mem_arb #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int MAX_CONSEC = 4
) (
   input  logic     clk,
   input  logic     rst,
   mem_arb_if.slave bus,
   output logic     busy,
   output logic     owner
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
   localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);
   localparam bit         LAT_ONE    = (MEM_LAT == 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    consec_q, consec_d;
   logic          owner_q, owner_d;
   logic          store_q, store_d;
   logic          busy_q, busy_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_rdy_q, if_rdy_d;
   logic          dm_rdy_q, dm_rdy_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;

   // Next-state, arbitration and response-capture logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      consec_d    = consec_q;
      owner_d     = owner_q;
      store_d     = store_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdy_d    = 1'b0;
      dm_rdy_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         ST_IDLE: begin
            // While a rdy pulse is out, the finished requester's req is still stale.
            if ((bus.if_req || bus.dm_req) && !(if_rdy_q || dm_rdy_q)) begin
               state_d  = ST_ISSUE;
               mem_en_d = 1'b1;
               if (bus.dm_req && !(bus.if_req && (consec_q == CONSEC_MAX))) begin
                  owner_d     = 1'b1;
                  store_d     = bus.dm_we;
                  mem_we_d    = bus.dm_we;
                  mem_addr_d  = bus.dm_addr;
                  mem_wdata_d = bus.dm_wdata;
                  if (bus.if_req) begin
                     consec_d = (consec_q == CONSEC_MAX) ? CONSEC_MAX : consec_q + 4'd1;
                  end else begin
                     consec_d = 4'd0;
                  end
               end else begin
                  owner_d    = 1'b0;
                  store_d    = 1'b0;
                  mem_addr_d = bus.if_addr;
                  consec_d   = 4'd0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d = LAT_M1;
            if (LAT_ONE) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!owner_q) begin
               if_rdata_d = bus.mem_rdata;
               if_rdy_d   = 1'b1;
            end else if (!store_q) begin
               dm_rdata_d = bus.mem_rdata;
               dm_rdy_d   = 1'b1;
            end else begin
               dm_rdy_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         consec_q    <= 4'd0;
         owner_q     <= 1'b0;
         store_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= {DW{1'b0}};
         if_rdy_q    <= 1'b0;
         dm_rdy_q    <= 1'b0;
         if_rdata_q  <= {DW{1'b0}};
         dm_rdata_q  <= {DW{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         consec_q    <= consec_d;
         owner_q     <= owner_d;
         store_q     <= store_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdy_q    <= if_rdy_d;
         dm_rdy_q    <= dm_rdy_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign bus.if_rdy    = if_rdy_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdy    = dm_rdy_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign busy          = busy_q;
   assign owner         = owner_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a MEM_LAT=2 instance for most scenarios and a MEM_LAT=1
// instance for back-to-back timing, with per-requester expected-data queues.
module tb_mem_arb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arb_if #(.AW(16), .DW(32)) bus0 ();
   mem_arb_if #(.AW(16), .DW(32)) bus1 ();
   logic busy0, owner0, busy1, owner1;

   mem_arb #(.AW(16), .DW(32), .MEM_LAT(2), .MAX_CONSEC(4)) u_dut (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .owner(owner0));
   mem_arb #(.AW(16), .DW(32), .MEM_LAT(1), .MAX_CONSEC(4)) u_dut_lat1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .owner(owner1));

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_if0[$];
   logic [31:0] sb_dm0[$];
   logic [31:0] sb_dm1[$];
   logic [31:0] model_dm0 = 32'd0;
   logic [31:0] model_dm1 = 32'd0;

   function automatic logic [31:0] data_of(input logic [15:0] a);
      return {16'h8800, a} ^ 32'h0000_0011;
   endfunction

   // Memory model: read data appears exactly MEM_LAT cycles after mem_en, garbage otherwise.
   logic        p0_v0 = 1'b0, p1_v0 = 1'b0, p0_v1 = 1'b0;
   logic [15:0] p0_a0 = 16'd0, p1_a0 = 16'd0, p0_a1 = 16'd0;
   always @(posedge clk) begin
      p0_v0 <= bus0.mem_en;
      p0_a0 <= bus0.mem_addr;
      p1_v0 <= p0_v0;
      p1_a0 <= p0_a0;
      p0_v1 <= bus1.mem_en;
      p0_a1 <= bus1.mem_addr;
   end
   assign bus0.mem_rdata = p1_v0 ? data_of(p1_a0) : 32'hBAD0_BAD0;
   assign bus1.mem_rdata = p0_v1 ? data_of(p0_a1) : 32'hBAD0_BAD0;

   int          cyc = 0;
   int          en_cnt0 = 0, en_cyc0 = 0, we_cnt0 = 0, dmrdy_cnt0 = 0, viol0 = 0, viol1 = 0;
   logic [15:0] en_addr0 = 16'd0;
   logic [31:0] en_wdata0 = 32'd0;
   logic        en_we0 = 1'b0;
   logic [15:0] gmask0 = 16'd0;
   logic        prev_en0 = 1'b0, prev_en1 = 1'b0;

   // Bus monitor: strobe snapshots, grant-owner history and protocol violations.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_en0 <= bus0.mem_en;
      prev_en1 <= bus1.mem_en;
      if (bus0.mem_en) begin
         en_cnt0   <= en_cnt0 + 1;
         en_cyc0   <= cyc;
         en_addr0  <= bus0.mem_addr;
         en_we0    <= bus0.mem_we;
         en_wdata0 <= bus0.mem_wdata;
         gmask0    <= {gmask0[14:0], owner0};
      end
      if (bus0.mem_we) we_cnt0 <= we_cnt0 + 1;
      if (bus0.dm_rdy) dmrdy_cnt0 <= dmrdy_cnt0 + 1;
      if ((bus0.mem_en && prev_en0) || (bus0.if_rdy && bus0.dm_rdy)) viol0 <= viol0 + 1;
      if ((bus1.mem_en && prev_en1) || (bus1.if_rdy && bus1.dm_rdy)) viol1 <= viol1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag, input logic [5:0] ctl, input logic [15:0] addr,
                           input logic [31:0] wd, input logic [31:0] ifd, input logic [31:0] dmd);
      check({tag, "_ctl"}, 32'(ctl), 32'd0);
      check({tag, "_addr"}, 32'(addr), 32'd0);
      check({tag, "_wdata"}, wd, 32'd0);
      check({tag, "_if_rdata"}, ifd, 32'd0);
      check({tag, "_dm_rdata"}, dmd, 32'd0);
   endtask

   task automatic req_if0(input logic [15:0] a);
      bus0.if_req  = 1'b1;
      bus0.if_addr = a;
      sb_if0.push_back(data_of(a));
   endtask

   task automatic req_dm0(input logic we, input logic [15:0] a, input logic [31:0] wd);
      bus0.dm_req   = 1'b1;
      bus0.dm_we    = we;
      bus0.dm_addr  = a;
      bus0.dm_wdata = wd;
      if (!we) model_dm0 = data_of(a);
      sb_dm0.push_back(model_dm0);
   endtask

   task automatic serve0(input string tag, output logic was_dm);
      logic got;
      logic [31:0] e;
      got    = 1'b0;
      was_dm = 1'b0;
      e      = 32'hFFFF_FFFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus0.if_rdy || bus0.dm_rdy) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_rdy_seen"}, 32'(got), 32'd1);
      if (got) begin
         was_dm = bus0.dm_rdy;
         check({tag, "_owner"}, 32'(owner0), 32'(was_dm));
         if (was_dm) begin
            if (sb_dm0.size() > 0) e = sb_dm0.pop_front();
            check({tag, "_dm_rdata"}, bus0.dm_rdata, e);
            bus0.dm_req = 1'b0;
         end else begin
            if (sb_if0.size() > 0) e = sb_if0.pop_front();
            check({tag, "_if_rdata"}, bus0.if_rdata, e);
            bus0.if_req = 1'b0;
         end
      end
   endtask

   task automatic serve1(input string tag, output int at_cyc);
      logic got;
      logic [31:0] e;
      got    = 1'b0;
      at_cyc = 0;
      e      = 32'hFFFF_FFFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus1.dm_rdy || bus1.if_rdy) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_rdy_seen"}, 32'(got), 32'd1);
      if (got) begin
         at_cyc = cyc;
         if (sb_dm1.size() > 0) e = sb_dm1.pop_front();
         check({tag, "_dm_rdy"}, 32'(bus1.dm_rdy), 32'd1);
         check({tag, "_dm_rdata"}, bus1.dm_rdata, e);
         bus1.dm_req = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic was_dm;
      int   base, base_we, n_dm, t_prev, t_now;
      logic if_again, seen;

      rst = 1'b1;
      bus0.if_req = 1'b0; bus0.if_addr = 16'd0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
      bus0.dm_addr = 16'd0; bus0.dm_wdata = 32'd0;
      bus1.if_req = 1'b0; bus1.if_addr = 16'd0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
      bus1.dm_addr = 16'd0; bus1.dm_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset0", {bus0.if_rdy, bus0.dm_rdy, bus0.mem_en, bus0.mem_we, busy0, owner0},
               bus0.mem_addr, bus0.mem_wdata, bus0.if_rdata, bus0.dm_rdata);
      chk_zero("reset1", {bus1.if_rdy, bus1.dm_rdy, bus1.mem_en, bus1.mem_we, busy1, owner1},
               bus1.mem_addr, bus1.mem_wdata, bus1.if_rdata, bus1.dm_rdata);
      rst = 1'b0;

      // single fetch
      base = en_cnt0;
      req_if0(16'h0010);
      serve0("t1", was_dm);
      check("t1_is_fetch", 32'(was_dm), 32'd0);
      check("t1_en_count", 32'(en_cnt0 - base), 32'd1);
      check("t1_en_addr", 32'(en_addr0), 32'h0000_0010);
      check("t1_rdy_latency", 32'(cyc - en_cyc0), 32'd3);
      check("t1_if_rdata_lit", bus0.if_rdata, 32'h8800_0001);
      check("t1_busy_rdy_cycle", 32'(busy0), 32'd0);
      @(negedge clk);
      check("t1_busy_after", 32'(busy0), 32'd0);

      // load then store: store leaves dm_rdata at the load value
      req_dm0(1'b0, 16'h0040, 32'd0);
      serve0("t2_load", was_dm);
      base    = en_cnt0;
      base_we = we_cnt0;
      req_dm0(1'b1, 16'h0100, 32'hDEAD_BEEF);
      serve0("t2_store", was_dm);
      check("t2_is_data", 32'(was_dm), 32'd1);
      check("t2_en_count", 32'(en_cnt0 - base), 32'd1);
      check("t2_we_cycles", 32'(we_cnt0 - base_we), 32'd1);
      check("t2_en_we", 32'(en_we0), 32'd1);
      check("t2_en_addr", 32'(en_addr0), 32'h0000_0100);
      check("t2_en_wdata", en_wdata0, 32'hDEAD_BEEF);

      // simultaneous requests: data first, then fetch
      @(negedge clk);
      req_if0(16'h0020);
      req_dm0(1'b0, 16'h0030, 32'd0);
      serve0("t3_first", was_dm);
      check("t3_first_is_data", 32'(was_dm), 32'd1);
      serve0("t3_second", was_dm);
      check("t3_second_is_fetch", 32'(was_dm), 32'd0);
      check("t3_grant_order", 32'(gmask0[1:0]), 32'd2);

      // starvation guard: four data grants, forced fetch, data wins the next tie
      @(negedge clk);
      req_if0(16'h0200);
      req_dm0(1'b0, 16'h0300, 32'd0);
      n_dm     = 1;
      if_again = 1'b0;
      for (int k = 0; k < 7; k++) begin
         serve0("t4", was_dm);
         if (was_dm && n_dm < 5) begin
            req_dm0(1'b0, 16'(32'h0300 + n_dm), 32'd0);
            n_dm++;
         end else if (!was_dm && !if_again) begin
            req_if0(16'h0210);
            if_again = 1'b1;
         end
      end
      check("t4_grant_pattern", 32'(gmask0[6:0]), 32'h0000_007A);
      check("t4_if_queue_empty", 32'(sb_if0.size()), 32'd0);
      check("t4_dm_queue_empty", 32'(sb_dm0.size()), 32'd0);

      // reset during WAIT of a load
      @(negedge clk);
      base          = dmrdy_cnt0;
      bus0.dm_req   = 1'b1;
      bus0.dm_we    = 1'b0;
      bus0.dm_addr  = 16'h0500;
      seen          = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus0.mem_en) begin
            seen = 1'b1;
            break;
         end
      end
      check("t5_issue_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("t5_busy_in_wait", 32'(busy0), 32'd1);
      check("t5_owner_in_wait", 32'(owner0), 32'd1);
      rst         = 1'b1;
      bus0.dm_req = 1'b0;
      @(negedge clk);
      chk_zero("t5_reset", {bus0.if_rdy, bus0.dm_rdy, bus0.mem_en, bus0.mem_we, busy0, owner0},
               bus0.mem_addr, bus0.mem_wdata, bus0.if_rdata, bus0.dm_rdata);
      rst       = 1'b0;
      model_dm0 = 32'd0;
      repeat (8) @(negedge clk);
      check("t5_no_rdy", 32'(dmrdy_cnt0 - base), 32'd0);
      req_dm0(1'b0, 16'h0600, 32'd0);
      serve0("t5_after", was_dm);
      check("t5_after_is_data", 32'(was_dm), 32'd1);

      // MEM_LAT=1 back-to-back loads
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         bus1.dm_req  = 1'b1;
         bus1.dm_we   = 1'b0;
         bus1.dm_addr = 16'(32'h0700 + k);
         model_dm1    = data_of(bus1.dm_addr);
         sb_dm1.push_back(model_dm1);
         serve1("t6", t_now);
         if (k > 0) check("t6_rdy_spacing", 32'(t_now - t_prev), 32'd4);
         t_prev = t_now;
      end
      check("t6_owner", 32'(owner1), 32'd1);

      @(negedge clk);
      check("viol_lat2", 32'(viol0), 32'd0);
      check("viol_lat1", 32'(viol1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
